fir_decim_out: RTL and testbench

FIR_DECIM_OUT -- requirements
Module: fir_decim_out

---
 rtl/fir_pkg.sv | 10 +
 rtl/fir_sync_fifo.sv | 63 ++++++
 rtl/fir_decim_out.sv | 99 +++++++++
 tb/tb_fir_decim_out.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared sample widths and typedefs for the FIR decimator output stage.
package fir_pkg;
    localparam int unsigned FIR_IN_W  = 16;
    localparam int unsigned FIR_OUT_W = 8;
    localparam int unsigned FIR_SCL_W = FIR_IN_W + 1;

    typedef logic signed [FIR_IN_W-1:0]  in_sample_t;
    typedef logic signed [FIR_SCL_W-1:0] scaled_t;
    typedef logic signed [FIR_OUT_W-1:0] sample_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO of scaled samples: storage, wrapping pointers and occupancy.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  sample_t                    push_data,
    input  logic                       pop,
    output sample_t                    pop_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    sample_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   cnt;
    logic               full_c;
    logic               do_pop_c;
    logic               do_push_c;

    // A push into a full FIFO still lands when the head leaves on the same edge.
    always_comb begin
        full_c    = (cnt == LVL_W'(DEPTH));
        do_pop_c  = pop && (cnt != '0);
        do_push_c = push && (!full_c || do_pop_c);
        drop_c    = push && full_c && !do_pop_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push_c, do_pop_c})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign valid    = (cnt != '0);
    assign level    = cnt;
endmodule

// File: rtl/fir_decim_out.sv
// Decimate, round-scale and buffer filter output samples.
// Define FIR_DECIM_SAT_EN to clamp scaled samples to 8 bits instead of wrapping.
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int unsigned DECIM = 2,
    parameter int unsigned SHIFT = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  in_sample_t                 in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output sample_t                    out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop_flag,
    output logic                       sat_flag
);
    localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam scaled_t     RND  = scaled_t'(2 ** (SHIFT - 1));

    logic [PH_W-1:0] phase;
    logic            keep_c;
    logic            drop_c;
    logic            clip_c;
    scaled_t         sum_c;
    scaled_t         r_c;
    sample_t         samp_c;

    // Sign-extend to 17 bits so the rounding offset can never overflow.
    always_comb begin
        keep_c = in_valid && (phase == '0);
        sum_c  = {in_data[FIR_IN_W-1], in_data} + RND;
        r_c    = sum_c >>> SHIFT;
    end

`ifdef FIR_DECIM_SAT_EN
    localparam scaled_t SAT_MAX = 17'sd127;
    localparam scaled_t SAT_MIN = -17'sd128;
    localparam sample_t OUT_MAX = 8'h7F;
    localparam sample_t OUT_MIN = 8'h80;

    always_comb begin
        samp_c = r_c[FIR_OUT_W-1:0];
        clip_c = 1'b0;
        if (r_c > SAT_MAX) begin
            samp_c = OUT_MAX;
            clip_c = 1'b1;
        end else if (r_c < SAT_MIN) begin
            samp_c = OUT_MIN;
            clip_c = 1'b1;
        end
    end
`else
    logic unused_hi_c;

    always_comb begin
        samp_c = r_c[FIR_OUT_W-1:0];
        clip_c = 1'b0;
    end

    assign unused_hi_c = ^r_c[FIR_SCL_W-1:FIR_OUT_W];
`endif

    // Phase advances on every accepted sample, kept, discarded or dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase     <= '0;
            drop_flag <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (in_valid) begin
                phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
            if (drop_c) begin
                drop_flag <= 1'b1;
            end
            if (keep_c && clip_c) begin
                sat_flag <= 1'b1;
            end
        end
    end

    fir_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (keep_c),
        .push_data (samp_c),
        .pop       (out_ready),
        .pop_data  (out_data),
        .valid     (out_valid),
        .level     (level),
        .drop_c    (drop_c)
    );
endmodule

// File: tb/tb_fir_decim_out.sv
// Scoreboard bench for fir_decim_out with DECIM=2, SHIFT=4, DEPTH=4.
module tb_fir_decim_out;
    localparam int unsigned DECIM = 2;
    localparam int unsigned SHIFT = 4;
    localparam int unsigned DEPTH = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic signed [15:0]        in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [7:0]         out_data;
    logic [$clog2(DEPTH):0]    level;
    logic                      drop_flag;
    logic                      sat_flag;

    int n_tests  = 0;
    int n_fail   = 0;
    int sb_tests = 0;
    int sb_fail  = 0;
    int sb_idx   = 0;

    logic signed [7:0] exp_q [$];

    always #5 clk = ~clk;

    fir_decim_out #(
        .DECIM (DECIM),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .drop_flag (drop_flag),
        .sat_flag  (sat_flag)
    );

    // Monitor: every handshake seen before the edge consumes the next expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_idx = exp_q.size();
        end else if (out_valid && out_ready) begin
            sb_tests++;
            if (sb_idx >= exp_q.size()) begin
                sb_fail++;
                $display("FAIL sb_unexpected: got %0d, expected no output", out_data);
            end else begin
                if (out_data !== exp_q[sb_idx]) begin
                    sb_fail++;
                    $display("FAIL sb_data[%0d]: got %0d, expected %0d",
                             sb_idx, out_data, exp_q[sb_idx]);
                end
                sb_idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int d, input bit enq, input int expv);
        tick();
        in_valid = 1'b1;
        in_data  = 16'(d);
        if (enq) exp_q.push_back(8'(expv));
    endtask

    task automatic stop_input();
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        tick();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb_idx != exp_q.size(); i++) tick();
        check(name, exp_q.size() - sb_idx, 0);
        check({name, "_level"}, int'(level), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_level", int'(level), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_drop", int'(drop_flag), 0);
        check("rst_sat", int'(sat_flag), 0);
        rst_n = 1'b1;

        // Rounding: 24 -> 2, -8 -> 0, -9 -> -1
        out_ready = 1'b1;
        send(24, 1'b1, 2);
        send(1000, 1'b0, 0);
        send(-8, 1'b1, 0);
        send(1000, 1'b0, 0);
        send(-9, 1'b1, -1);
        stop_input();
        wait_drain("round_drain");
        check("round_drop", int'(drop_flag), 0);

        // Saturation / wrap of extreme inputs
        do_reset();
        out_ready = 1'b1;
`ifdef FIR_DECIM_SAT_EN
        send(32767, 1'b1, 127);
        send(0, 1'b0, 0);
        send(-32768, 1'b1, -128);
`else
        send(32767, 1'b1, 0);
        send(0, 1'b0, 0);
        send(-32768, 1'b1, 0);
`endif
        stop_input();
        wait_drain("sat_drain");
`ifdef FIR_DECIM_SAT_EN
        check("sat_flag", int'(sat_flag), 1);
`else
        check("sat_flag", int'(sat_flag), 0);
`endif

        // Decimation with latency-1 out_valid
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i > 0) check("decim_valid", int'(out_valid), ((i - 1) % 2 == 0) ? 1 : 0);
            in_valid = 1'b1;
            in_data  = 16'(16 * (i + 1));
            if (i % 2 == 0) exp_q.push_back(8'(i + 1));
        end
        tick();
        check("decim_valid_last", int'(out_valid), 0);
        in_valid = 1'b0;
        wait_drain("decim_drain");

        // Overflow: 12 inputs, 6 kept, 4 stored
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            send(16 * (k + 1), (k % 2 == 0) && (k < 8), k + 1);
        end
        stop_input();
        check("ovf_level", int'(level), 4);
        check("ovf_drop", int'(drop_flag), 1);
        check("ovf_valid", int'(out_valid), 1);
        check("ovf_head", int'(out_data), 1);
        tick();
        check("ovf_head_stable", int'(out_data), 1);
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_drop_sticky", int'(drop_flag), 1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send(16 * (k + 1), (k % 2 == 0), k + 1);
        end
        stop_input();
        check("full_level", int'(level), 4);
        tick();
        in_valid  = 1'b1;
        in_data   = 16'(144);
        out_ready = 1'b1;
        exp_q.push_back(8'(9));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("full_pushpop_level", int'(level), 4);
        check("full_pushpop_drop", int'(drop_flag), 0);
        out_ready = 1'b1;
        wait_drain("full_drain");

        // Reset mid-operation with three samples buffered
        do_reset();
        out_ready = 1'b0;
        send(16, 1'b0, 0);
        send(0, 1'b0, 0);
        send(32, 1'b0, 0);
        send(0, 1'b0, 0);
        send(48, 1'b0, 0);
        stop_input();
        check("mid_level", int'(level), 3);
        tick();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_drop", int'(drop_flag), 0);
        check("mid_rst_sat", int'(sat_flag), 0);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'(160);
        exp_q.push_back(8'(10));
        tick();
        in_valid = 1'b0;
        check("mid_kept_level", int'(level), 1);
        out_ready = 1'b1;
        wait_drain("mid_drain");

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests + sb_tests, n_fail + sb_fail);
        $finish;
    end
endmodule
